// File: rtl/debounce_filter.sv
// Button debouncer: two-flop synchroniser feeding a stability counter. The output follows the
// input only after it has held a new level for CLOCK_LIMIT-CLOCK_START+1 cycles. Define
// DEBOUNCE_PULSE_EN to add the one-cycle press output on each debounced 0->1 update.
`timescale 1ns/1ps
module debounce_filter #(
    parameter int                    CLOCK_SIZE  = 24,
    parameter logic [CLOCK_SIZE-1:0] CLOCK_START = 24'd0,
    parameter logic [CLOCK_SIZE-1:0] CLOCK_LIMIT = 24'd119999
) (
    input  logic clock,
    input  logic reset,
    input  logic in,
`ifdef DEBOUNCE_PULSE_EN
    output logic press,
`endif
    output logic out
);

    logic                  sync1_r;
    logic                  sync_r;
    logic [CLOCK_SIZE-1:0] count_r;
    logic [CLOCK_SIZE-1:0] count_next_s;
    logic                  out_next_s;
    logic                  differ_s;
    logic                  at_limit_s;

    assign differ_s   = (sync_r != out);
    assign at_limit_s = (count_r == CLOCK_LIMIT);

    // Two-flop synchroniser; sync_r is the only form of the pad level used below.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync_r  <= 1'b0;
        end else begin
            sync1_r <= in;
            sync_r  <= sync1_r;
        end
    end

    // Stability counter: any return to the current output level restarts the count.
    always_comb begin
        count_next_s = CLOCK_START;
        out_next_s   = out;
        if (!differ_s) begin
            count_next_s = CLOCK_START;
        end else if (at_limit_s) begin
            count_next_s = CLOCK_START;
            out_next_s   = sync_r;
        end else begin
            count_next_s = count_r + CLOCK_SIZE'(1);
        end
    end

    // Counter and debounced output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= CLOCK_START;
            out     <= 1'b0;
        end else begin
            count_r <= count_next_s;
            out     <= out_next_s;
        end
    end

`ifdef DEBOUNCE_PULSE_EN
    // press rises together with out, so it is high exactly in the first cycle out reads 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            press <= 1'b0;
        end else begin
            press <= differ_s & at_limit_s & sync_r;
        end
    end
`endif

endmodule

// File: tb/tb_debounce_filter.sv
// Scoreboard bench for debounce_filter with START=0, LIMIT=59 (62-edge step latency).
`timescale 1ns/1ps
module tb_debounce_filter;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic in    = 1'b0;
    logic out;
`ifdef DEBOUNCE_PULSE_EN
    logic press;
    int   n_press = 0;
    int   n_rise  = 0;
`endif

    int   cyc      = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    bit   mon_en   = 1'b0;
    logic prev_out = 1'b0;

    typedef struct {
        int    at;
        logic  val;
        string name;
    } exp_t;

    exp_t edge_q[$];
    exp_t lvl_q[$];

    debounce_filter #(
        .CLOCK_SIZE (24),
        .CLOCK_START(24'd0),
        .CLOCK_LIMIT(24'd59)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in   (in),
`ifdef DEBOUNCE_PULSE_EN
        .press(press),
`endif
        .out  (out)
    );

    always #41 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void expect_edge(input int at, input logic val, input string name);
        exp_t e;
        e.at = at; e.val = val; e.name = name;
        edge_q.push_back(e);
    endfunction

    function automatic void expect_level(input int at, input logic val, input string name);
        exp_t e;
        e.at = at; e.val = val; e.name = name;
        lvl_q.push_back(e);
    endfunction

    // Monitor: every change of out must match the next queued edge, in cycle and value.
    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            if (out !== prev_out) begin
                if (edge_q.size() == 0) begin
                    check("unexpected_edge", 32'(out), 32'(prev_out));
                end else begin
                    e = edge_q.pop_front();
                    check({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
                    check({e.name, "_value"}, 32'(out), 32'(e.val));
                end
            end
            while (lvl_q.size() > 0 && lvl_q[0].at <= cyc) begin
                e = lvl_q.pop_front();
                check(e.name, 32'(out), 32'(e.val));
            end
`ifdef DEBOUNCE_PULSE_EN
            if (out === 1'b1 && prev_out === 1'b0) begin
                n_rise++;
                check("press_on_rise", 32'(press), 32'd1);
            end
            if (press === 1'b1) begin
                n_press++;
                check("press_first_cycle", 32'({prev_out, out}), 32'd1);
            end
`endif
        end
        prev_out = out;
    end

    initial begin
        int c;
        // Reset pulse: output must clear without waiting for a clock edge.
        #10 reset = 1'b1;
        #1;
        check("reset_async_out", 32'(out), 32'd0);
        check("reset_count", 32'(dut.count_r), 32'd0);
`ifdef DEBOUNCE_PULSE_EN
        check("reset_press", 32'(press), 32'd0);
`endif
        #14 reset = 1'b0;
        mon_en = 1'b1;

        // 1 ms idle with in=0.
        expect_level(cyc + 12195, 1'b0, "idle_out_low");
        repeat (12200) @(negedge clock);

        // Bounce train of 7 toggles; the final low lasts longer than a clock period.
        @(negedge clock);
        in = 1'b1; #60 in = 1'b0; #90 in = 1'b1; #110 in = 1'b0;
        #50 in = 1'b1; #70 in = 1'b0; #130 in = 1'b1;
        expect_edge(cyc + 62, 1'b1, "bounce_rise");
        repeat (70) @(negedge clock);
        expect_level(cyc, 1'b1, "bounce_hold_high");

        // 40-cycle low glitch is rejected and the count restarts.
        @(negedge clock);
        in = 1'b0;
        repeat (40) @(negedge clock);
        in = 1'b1;
        repeat (3) @(negedge clock);
        check("glitch_count_cleared", 32'(dut.count_r), 32'd0);
        expect_level(cyc + 60, 1'b1, "glitch_out_high");
        repeat (65) @(negedge clock);

        // Clean falling step.
        in = 1'b0;
        expect_edge(cyc + 62, 1'b0, "fall");
        repeat (70) @(negedge clock);

        // 59 cycles high is one short of the terminal count.
        in = 1'b1;
        repeat (59) @(negedge clock);
        in = 1'b0;
        repeat (70) @(negedge clock);
        expect_level(cyc, 1'b0, "short59_out_low");
        @(negedge clock);

        // 60 cycles high is just enough; the following low then takes the full count.
        c = cyc;
        in = 1'b1;
        expect_edge(c + 62, 1'b1, "long60_rise");
        repeat (60) @(negedge clock);
        in = 1'b0;
        expect_edge(c + 122, 1'b0, "long60_fall");
        repeat (70) @(negedge clock);

        // Reset while out=1 and a falling count is in progress.
        in = 1'b1;
        expect_edge(cyc + 62, 1'b1, "pre_reset_rise");
        repeat (70) @(negedge clock);
        in = 1'b0;
        repeat (20) @(negedge clock);
        check("mid_count", 32'(dut.count_r), 32'd18);
        mon_en = 1'b0;
        in = 1'b1;
        #10 reset = 1'b1;
        #1;
        check("reset_mid_out", 32'(out), 32'd0);
        check("reset_mid_count", 32'(dut.count_r), 32'd0);
        #5 reset = 1'b0;
        c = cyc;
        @(negedge clock);
        #1 mon_en = 1'b1;
        expect_edge(c + 62, 1'b1, "post_reset_rise");
        repeat (70) @(negedge clock);
        expect_level(cyc, 1'b1, "post_reset_high");
        repeat (3) @(negedge clock);

        check("pending_edges", 32'(edge_q.size()), 32'd0);
        check("pending_levels", 32'(lvl_q.size()), 32'd0);
`ifdef DEBOUNCE_PULSE_EN
        check("press_count", 32'(n_press), 32'(n_rise));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
